seq_10110_tx: RTL and testbench
===============================

Name: seq_10110_tx

Overview:
- Serial pattern transmitter: the transmit-side counterpart of the 10110 Mealy overlapping sequence detector.
- Drives a configurable number of 10110 frames onto a one-bit serial line, MSB first, one bit per clock.
- Frames are separated either by an idle gap or, in overlap mode, by sharing the "10" prefix/suffix.
- Emits frame_end on the cycle a detector should fire, so it serves both as stimulus source and as reference model for detector benches.

Parameters:
- PAT_W, 5, pattern length in bits.
- PATTERN, 5'b10110, pattern sent MSB first.
- OVL, 2, length of the longest proper prefix that is also a suffix of PATTERN. Must satisfy OVL < PAT_W.
- CNT_W, 4, width of the repeat count.
- GAP_W, 3, width of the gap length.
- IDLE_BIT, 1'b0, value driven on out_seq when out_valid=0.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low.
- start  in  1  request pulse; accepted only when busy=0.
- rep_cnt  in  CNT_W  number of frames to send; sampled on accepted start.
- gap_len  in  GAP_W  idle cycles between frames; sampled on accepted start.
- ovl_en  in  1  overlap mode; sampled on accepted start.
- out_seq  out  1  serial data.
- out_valid  out  1  out_seq carries a pattern bit.
- frame_end  out  1  high while the last bit of a frame is driven.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse after the last bit.

Behaviour:
- Reset: on any edge with rst=0, all outputs are registered.
  - out_seq=IDLE_BIT, out_valid=0, frame_end=0, busy=0, done=0.
  - State goes to IDLE; counters clear.
  - Applies mid-transfer: the transfer is aborted with no done pulse.
- States: IDLE, SEND, GAP.
- IDLE:
  - On start=1: latch rep_cnt, gap_len, ovl_en; busy=1 from the next cycle.
  - If rep_cnt=0: stay in IDLE, pulse done the next cycle, send no bits.
  - Otherwise go to SEND with idx=PAT_W-1 and frames_left=rep_cnt.
- Latency: the first bit appears on out_seq/out_valid one cycle after the start edge.
- SEND:
  - Each cycle: out_seq=PATTERN[idx], out_valid=1, then idx decrements.
  - frame_end=1 when idx=0; on that edge frames_left decrements.
  - After the last bit with frames_left=1: next cycle is IDLE with out_valid=0, busy=0, done=1.
  - Else if gap_len>0: go to GAP.
  - Else if ovl_en=1: stay in SEND with idx=PAT_W-1-OVL, skipping the shared prefix.
  - Else: stay in SEND with idx=PAT_W-1.
- GAP:
  - Drives out_valid=0, out_seq=IDLE_BIT for exactly gap_len cycles, then SEND with idx=PAT_W-1.
  - A gap always restarts a full frame, even with ovl_en=1.
- Inputs are ignored while busy=1. A start held high through the done cycle is accepted in that cycle, since state is IDLE and busy=0.
- Bit counts:
  - Total valid bits = rep_cnt*PAT_W when gap_len>0 or ovl_en=0.
  - Total valid bits = PAT_W+(rep_cnt-1)*(PAT_W-OVL) for overlap with gap_len=0.
- Max rep_cnt = 2^CNT_W-1; no wrap.

Decomposition:
- Package seq_10110_pkg holds:
  - PAT_W, PATTERN, OVL constants.
  - State encodings ST_IDLE, ST_SEND, ST_GAP.
  - A static check that OVL<PAT_W and that PATTERN[OVL-1:0] equals PATTERN[PAT_W-1:PAT_W-OVL].
- One sub-module, seq_tx_downcnt: a loadable down-counter with a zero flag. It is instantiated for frames_left and for the gap counter; the FSM and bit index stay in the top level.

Test Plan:
- Reset then start, rep_cnt=1, gap_len=0, ovl_en=0 -> out_seq 1,0,1,1,0 on cycles T+1..T+5; frame_end only at T+5; done at T+6; busy high T+1..T+5.
- rep_cnt=2, gap_len=0, ovl_en=0 -> 10 valid bits 1011010110; frame_end at bits 5 and 10; a detector DUT asserts det_out on the same cycles.
- rep_cnt=2, gap_len=0, ovl_en=1 -> 8 bits 10110110; frame_end at bits 5 and 8; rep_cnt=3 gives 11 bits 10110110110.
- rep_cnt=2, gap_len=3, ovl_en=1 -> 10110, then 3 cycles with out_valid=0 and out_seq=0, then a full 10110; done one cycle after the last bit.
- rep_cnt=0 -> no valid bits, busy stays 0, done pulses one cycle after start. start pulsed mid-transfer -> ignored, bit stream unchanged.
- rst=0 asserted on the 3rd bit of frame 1 -> next cycle all outputs zero, no done; new start after rst=1 yields a clean 10110.

Source files
------------

// File: rtl/seq_10110_pkg.sv
// Shared constants, state encoding and pattern sanity check for the 10110 serial transmitter.
package seq_10110_pkg;

  localparam int PAT_W = 5;
  localparam logic [PAT_W-1:0] PATTERN = 5'b10110;
  localparam int OVL = 2;
  localparam int IDX_W = $clog2(PAT_W);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Leading OVL bits of the pattern must equal its trailing OVL bits for overlap mode to be legal.
  function automatic bit pat_ok();
    if (OVL >= PAT_W) return 1'b0;
    for (int i = 0; i < OVL; i++) begin
      if (PATTERN[i] != PATTERN[PAT_W-OVL+i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  localparam bit PAT_OK = pat_ok();

endpackage

// File: rtl/seq_tx_downcnt.sv
// Loadable down-counter with zero flag; holds at zero instead of wrapping.
module seq_tx_downcnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/seq_10110_tx.sv
// Serial 10110 frame transmitter: repeated frames, optional idle gap or shared-prefix overlap,
// with frame_end marking the cycle a matching detector should fire.
module seq_10110_tx
  import seq_10110_pkg::*;
#(
  parameter int   CNT_W    = 4,
  parameter int   GAP_W    = 3,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] rep_cnt,
  input  logic [GAP_W-1:0] gap_len,
  input  logic             ovl_en,
  output logic             out_seq,
  output logic             out_valid,
  output logic             frame_end,
  output logic             busy,
  output logic             done
);

  // state   | meaning
  // ST_IDLE | line idle, waiting for an accepted start
  // ST_SEND | pattern bit PATTERN[idx] is on the line
  // ST_GAP  | idle cycles between two full frames

  if (!PAT_OK) begin : g_pat_chk
    $error("seq_10110_tx: PATTERN/OVL combination is not a valid self-overlap");
  end

  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);
  localparam logic [IDX_W-1:0] IDX_OVL = IDX_W'(PAT_W - 1 - OVL);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_dec;
  logic [GAP_W-1:0] gap_q;
  logic             ovl_q;

  logic frm_load, frm_dec, frm_zero;
  logic gap_load, gap_dec, gap_zero;
  logic last_bit;

  assign idx_dec  = idx - 1'b1;
  assign last_bit = (state == ST_SEND) && (idx == '0);

  // frames_left holds the number of frames still to follow the current one
  assign frm_load = (state == ST_IDLE) && start && (rep_cnt != '0);
  assign frm_dec  = last_bit && !frm_zero;

  // gap counter is loaded with gap_len-1 so its zero flag marks the final idle cycle
  assign gap_load = last_bit && !frm_zero && (gap_q != '0);
  assign gap_dec  = (state == ST_GAP) && !gap_zero;

  seq_tx_downcnt #(.W(CNT_W)) u_frames_left (
    .clk      (clk),
    .rst      (rst),
    .load     (frm_load),
    .load_val (rep_cnt - 1'b1),
    .dec      (frm_dec),
    .zero     (frm_zero)
  );

  seq_tx_downcnt #(.W(GAP_W)) u_gap_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (gap_q - 1'b1),
    .dec      (gap_dec),
    .zero     (gap_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      gap_q     <= '0;
      ovl_q     <= 1'b0;
      out_seq   <= IDLE_BIT;
      out_valid <= 1'b0;
      frame_end <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      out_seq   <= IDLE_BIT;
      out_valid <= 1'b0;
      frame_end <= 1'b0;
      done      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            gap_q <= gap_len;
            ovl_q <= ovl_en;
            if (rep_cnt == '0) begin
              done <= 1'b1;
            end else begin
              state     <= ST_SEND;
              busy      <= 1'b1;
              idx       <= IDX_TOP;
              out_seq   <= PATTERN[IDX_TOP];
              out_valid <= 1'b1;
            end
          end
        end
        ST_SEND: begin
          if (idx != '0) begin
            idx       <= idx_dec;
            out_seq   <= PATTERN[idx_dec];
            out_valid <= 1'b1;
            frame_end <= (idx_dec == '0);
          end else if (frm_zero) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (gap_q != '0) begin
            state <= ST_GAP;
          end else if (ovl_q) begin
            // shared prefix was already sent as the tail of the previous frame
            idx       <= IDX_OVL;
            out_seq   <= PATTERN[IDX_OVL];
            out_valid <= 1'b1;
            frame_end <= (IDX_OVL == '0);
          end else begin
            idx       <= IDX_TOP;
            out_seq   <= PATTERN[IDX_TOP];
            out_valid <= 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_zero) begin
            state     <= ST_SEND;
            idx       <= IDX_TOP;
            out_seq   <= PATTERN[IDX_TOP];
            out_valid <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_10110_tx.sv
// Scoreboard bench for seq_10110_tx: a string-based frame model predicts every valid bit and done
// pulse with its absolute cycle; a negedge monitor pops and compares whenever the DUT presents output.
module tb_seq_10110_tx;

  localparam int PAT_W = 5;
  localparam int OVL   = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [3:0] rep_cnt = '0;
  logic [2:0] gap_len = '0;
  logic       ovl_en = 1'b0;
  logic       out_seq, out_valid, frame_end, busy, done;

  seq_10110_tx dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rep_cnt   (rep_cnt),
    .gap_len   (gap_len),
    .ovl_en    (ovl_en),
    .out_seq   (out_seq),
    .out_valid (out_valid),
    .frame_end (frame_end),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int t;
    bit seq;
    bit fe;
    bit dn;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Frame stream built from the pattern text: overlap drops the first OVL characters of later frames.
  task automatic push_expected(input int base, input int rep, input int gap, input bit ovl);
    string pat = "10110";
    int    t = 0;
    int    first;
    byte   c;
    exp_t  e;
    for (int f = 0; f < rep; f++) begin
      first = 0;
      if (f > 0) begin
        if (gap > 0) t += gap;
        else if (ovl) first = OVL;
      end
      for (int p = first; p < PAT_W; p++) begin
        t++;
        c = pat[p];
        e.t = base + t; e.seq = (c == "1"); e.fe = (p == PAT_W - 1); e.dn = 1'b0;
        sb.push_back(e);
      end
    end
    e.t = base + t + 1; e.seq = 1'b0; e.fe = 1'b0; e.dn = 1'b1;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (out_valid === 1'b1 || done === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: valid=%b done=%b at cycle %0d, nothing expected", out_valid, done, cyc);
        end else begin
          e = sb.pop_front();
          check("timing", cyc, e.t);
          check("out_valid", out_valid, !e.dn);
          check("done", done, e.dn);
          if (!e.dn) begin
            check("out_seq", out_seq, e.seq);
            check("frame_end", frame_end, e.fe);
            check("busy_in_frame", busy, 1);
          end else begin
            check("busy_at_done", busy, 0);
          end
        end
      end else begin
        check("idle_out_seq", out_seq, 0);
        check("idle_frame_end", frame_end, 0);
      end
    end
  end

  // Called at a negedge; the accepting edge is the next posedge.
  task automatic issue(input int rep, input int gap, input bit ovl);
    rep_cnt = 4'(rep);
    gap_len = 3'(gap);
    ovl_en  = ovl;
    start   = 1'b1;
    push_expected(cyc, rep, gap, ovl);
    @(negedge clk);
    start   = 1'b0;
    rep_cnt = 4'($urandom_range(0, 15));
    gap_len = 3'($urandom_range(0, 7));
    ovl_en  = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle(input bit noise);
    int i;
    for (i = 0; i < 400; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
      if (noise && busy === 1'b1 && $urandom_range(0, 2) == 0) begin
        rep_cnt = 4'($urandom_range(0, 15));
        gap_len = 3'($urandom_range(0, 7));
        ovl_en  = 1'($urandom_range(0, 1));
        start   = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL wait_timeout: %0d expected outputs never appeared", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int rep, gap;
    bit ovl;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_seq", out_seq, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_frame_end", frame_end, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    issue(1, 0, 0); wait_idle(1'b0);
    issue(2, 0, 0); wait_idle(1'b1);
    issue(2, 0, 1); wait_idle(1'b1);
    issue(3, 0, 1); wait_idle(1'b0);
    issue(2, 3, 1); wait_idle(1'b1);
    issue(0, 2, 1); wait_idle(1'b0);
    check("rep0_busy", busy, 0);
    issue(15, 0, 1); wait_idle(1'b1);
    issue(4, 7, 0); wait_idle(1'b0);
    @(negedge clk);

    // start presented during the done cycle must be accepted
    issue(2, 0, 0);
    for (int i = 0; i < 100; i++) begin
      if (done === 1'b1) break;
      @(negedge clk);
    end
    check("chain_done_seen", done, 1);
    issue(1, 0, 1); wait_idle(1'b0);

    // abort on the third bit of the first frame
    issue(3, 1, 0);
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check("abort_out_seq", out_seq, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_frame_end", frame_end, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    issue(1, 0, 0); wait_idle(1'b0);

    for (int n = 0; n < 30; n++) begin
      rep = $urandom_range(0, 15);
      gap = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 7);
      ovl = 1'($urandom_range(0, 1));
      issue(rep, gap, ovl);
      wait_idle(1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
